// File: rtl/uart_pkg.sv
// Shared UART constants and the FIFO per-cycle operation encoding.
package uart_pkg;

   localparam int unsigned UART_DATA_W     = 8;
   localparam int unsigned UART_FIFO_DEPTH = 16;

   // Bit 1 = write accepted, bit 0 = read accepted.
   typedef enum logic [1:0] {
      FIFO_IDLE     = 2'b00,
      FIFO_POP      = 2'b01,
      FIFO_PUSH     = 2'b10,
      FIFO_PUSH_POP = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-consumer FIFO bus: write strobe, pop request and status.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = UART_DATA_W,
   parameter int unsigned DEPTH  = UART_FIFO_DEPTH
) ();

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] wr_data;
   logic              wr_en;
   logic              rd_en;
   logic              ovf_clr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   modport master (
      output wr_data, wr_en, rd_en, ovf_clr,
      input  rd_data, rd_valid, empty, full, almost_full, count, overflow
   );

   modport slave (
      input  wr_data, wr_en, rd_en, ovf_clr,
      output rd_data, rd_valid, empty, full, almost_full, count, overflow
   );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W simple dual-port storage: sync write, registered read, no reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = UART_DATA_W,
   parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Read sees the pre-write contents when both ports hit the same entry.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      if (re) rdata <= mem_q[raddr];
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: pointers, occupancy, registered status flags and sticky overflow.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W   = UART_DATA_W,
   parameter int unsigned DEPTH    = UART_FIFO_DEPTH,
   parameter int unsigned AF_LEVEL = 12
) (
   input  logic           clk,
   input  logic           reset,
   uart_rx_fifo_if.slave  fifo
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              empty_q, full_q, af_q;
   logic              overflow_q, overflow_d;
   logic              rd_valid_q;
   logic              data_ok_q;
   logic              rd_acc, wr_acc, drop;
   logic [DATA_W-1:0] mem_rdata;
   fifo_op_e          op;

   always_comb begin
      rd_acc = fifo.rd_en && !empty_q && !reset;
      wr_acc = fifo.wr_en && (!full_q || rd_acc) && !reset;
      drop   = fifo.wr_en && full_q && !rd_acc && !reset;
      op     = fifo_op_e'({wr_acc, rd_acc});

      wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      unique case (op)
         FIFO_PUSH:     count_d = count_q + 1'b1;
         FIFO_POP:      count_d = count_q - 1'b1;
         FIFO_IDLE,
         FIFO_PUSH_POP: count_d = count_q;
      endcase

      // Set beats clear when a dropped write and ovf_clr coincide.
      overflow_d = overflow_q;
      if (drop)              overflow_d = 1'b1;
      else if (fifo.ovf_clr) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         af_q       <= 1'b0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
         data_ok_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= (count_d == '0);
         full_q     <= (count_d == DEPTH_CNT);
         af_q       <= (count_d >= AF_CNT);
         overflow_q <= overflow_d;
         rd_valid_q <= rd_acc;
         if (rd_acc) data_ok_q <= 1'b1;
      end
   end

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (fifo.wr_data),
      .re    (rd_acc),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   // The storage read register has no reset, so rd_data is forced to zero
   // from reset until the first accepted pop; afterwards it only changes on a pop.
   assign fifo.rd_data     = data_ok_q ? mem_rdata : '0;
   assign fifo.rd_valid    = rd_valid_q;
   assign fifo.empty       = empty_q;
   assign fifo.full        = full_q;
   assign fifo.almost_full = af_q;
   assign fifo.count       = count_q;
   assign fifo.overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AFL   = 12;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   logic [DW-1:0] m_q[$];
   logic          m_ovf = 1'b0;
   logic          m_rv  = 1'b0;
   logic [DW-1:0] m_rd  = '0;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
      .clk   (clk),
      .reset (reset),
      .fifo  (bus)
   );

   // One clock cycle: drive inputs, advance the model by the FIFO rules, sample 1ns after the edge.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
      bit racc;
      bit was_full;
      bus.wr_en = w; bus.wr_data = d; bus.rd_en = r; bus.ovf_clr = c; reset = rs;
      if (rs) begin
         m_q.delete(); m_ovf = 1'b0; m_rv = 1'b0; m_rd = '0;
      end else begin
         racc     = r && (m_q.size() != 0);
         was_full = (m_q.size() == DEPTH);
         m_rv     = racc;
         if (racc) m_rd = m_q.pop_front();
         if (w && (!was_full || racc)) m_q.push_back(d);
         if (w && was_full && !racc) m_ovf = 1'b1;
         else if (c)                 m_ovf = 1'b0;
      end
      @(posedge clk); #1;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset();
      step(0, 8'h00, 0, 0, 1);
      total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
      total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
      total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
      total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
   endtask

   task automatic test_basic();
      step(0, 8'h00, 0, 0, 1);
      step(1, 8'hA5, 0, 0, 0);
      step(1, 8'h3C, 0, 0, 0);
      total++; if (bus.count !== 5'd2 || bus.empty !== 1'b0) begin bad++; $display("FAIL basic_level got=%0d/%b exp=2/0", bus.count, bus.empty); end
      step(0, 8'h00, 1, 0, 0);
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin bad++; $display("FAIL basic_pop1 got=%b/%h exp=1/a5", bus.rd_valid, bus.rd_data); end
      step(0, 8'h00, 1, 0, 0);
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C) begin bad++; $display("FAIL basic_pop2 got=%b/%h exp=1/3c", bus.rd_valid, bus.rd_data); end
      step(0, 8'h00, 0, 0, 0);
      total++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h3C) begin bad++; $display("FAIL basic_hold got=%b/%h exp=0/3c", bus.rd_valid, bus.rd_data); end
      total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL basic_drained got=%0d/%b exp=0/1", bus.count, bus.empty); end
      step(0, 8'h00, 1, 0, 0);
      total++; if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin bad++; $display("FAIL basic_pop_empty got=%b/%0d exp=0/0", bus.rd_valid, bus.count); end
   endtask

   task automatic test_fill_overflow();
      step(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 16; i++) begin
         step(1, 8'(i), 0, 0, 0);
         total++;
         if (bus.count !== 5'(i + 1) || bus.almost_full !== (i + 1 >= 12) || bus.full !== (i + 1 == 16)) begin
            bad++; $display("FAIL fill_flags i=%0d got=%0d/%b/%b", i, bus.count, bus.almost_full, bus.full);
         end
      end
      step(1, 8'hFF, 0, 0, 0);
      total++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin bad++; $display("FAIL fill_drop got=%b/%0d exp=1/16", bus.overflow, bus.count); end
      for (int i = 0; i < 16; i++) begin
         step(0, 8'h00, 1, 0, 0);
         total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(i)) begin bad++; $display("FAIL fill_drain i=%0d got=%b/%h exp=1/%h", i, bus.rd_valid, bus.rd_data, 8'(i)); end
      end
      total++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin bad++; $display("FAIL fill_after got=%b/%b exp=1/1", bus.empty, bus.overflow); end
   endtask

   task automatic test_full_simul();
      step(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
      step(1, 8'h77, 1, 0, 0);
      total++; if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin bad++; $display("FAIL fullrw_level got=%0d/%b/%b exp=16/1/0", bus.count, bus.full, bus.overflow); end
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h00) begin bad++; $display("FAIL fullrw_pop got=%b/%h exp=1/00", bus.rd_valid, bus.rd_data); end
      for (int i = 0; i < 16; i++) begin
         step(0, 8'h00, 1, 0, 0);
         total++; if (bus.rd_data !== m_rd || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL fullrw_drain i=%0d got=%h exp=%h", i, bus.rd_data, m_rd); end
      end
      total++; if (bus.rd_data !== 8'h77 || bus.empty !== 1'b1) begin bad++; $display("FAIL fullrw_last got=%h/%b exp=77/1", bus.rd_data, bus.empty); end
   endtask

   task automatic test_empty_simul();
      step(0, 8'h00, 0, 0, 1);
      step(1, 8'h42, 1, 0, 0);
      total++; if (bus.count !== 5'd1 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL emptyrw got=%0d/%b exp=1/0", bus.count, bus.rd_valid); end
      step(0, 8'h00, 1, 0, 0);
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h42) begin bad++; $display("FAIL emptyrw_pop got=%b/%h exp=1/42", bus.rd_valid, bus.rd_data); end
   endtask

   task automatic test_wrap();
      step(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 40; i++) begin
         step(1, 8'(i + 8'h10), 0, 0, 0);
         total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL wrap_count i=%0d got=%0d exp=1", i, bus.count); end
         step(0, 8'h00, 1, 0, 0);
         total++; if (bus.rd_data !== 8'(i + 8'h10) || bus.count !== 5'd0) begin bad++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, bus.rd_data, 8'(i + 8'h10)); end
      end
   endtask

   task automatic test_reset_mid();
      step(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 17; i++) step(1, 8'($urandom), 0, 0, 0);
      for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0, 0);
      total++; if (bus.count !== 5'd5 || bus.overflow !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%b exp=5/1", bus.count, bus.overflow); end
      step(1, 8'h99, 1, 0, 1);
      total++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin
         bad++; $display("FAIL mid_reset got=%0d/%b/%b/%b/%h exp=0/1/0/0/00", bus.count, bus.empty, bus.overflow, bus.rd_valid, bus.rd_data);
      end
      for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
      step(1, 8'hEE, 0, 1, 0);
      total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL clr_vs_set got=%b exp=1", bus.overflow); end
      step(0, 8'h00, 0, 1, 0);
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", bus.overflow); end
   endtask

   task automatic test_random();
      bit w, r, c, rs;
      step(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 600; i++) begin
         w  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
         r  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
         c  = ($urandom_range(0, 15) == 0);
         rs = ($urandom_range(0, 199) == 0);
         step(w, 8'($urandom), r, c, rs);
         total++;
         if (bus.count !== 5'(m_q.size()) || bus.empty !== (m_q.size() == 0) || bus.full !== (m_q.size() == DEPTH)
             || bus.almost_full !== (m_q.size() >= AFL) || bus.overflow !== m_ovf || bus.rd_valid !== m_rv || bus.rd_data !== m_rd) begin
            bad++;
            $display("FAIL rand i=%0d got cnt=%0d e=%b f=%b af=%b ovf=%b rv=%b rd=%h exp cnt=%0d ovf=%b rv=%b rd=%h",
                     i, bus.count, bus.empty, bus.full, bus.almost_full, bus.overflow, bus.rd_valid, bus.rd_data,
                     m_q.size(), m_ovf, m_rv, m_rd);
         end
      end
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0; bus.wr_data = '0;
      test_reset();
      test_basic();
      test_fill_overflow();
      test_full_simul();
      test_empty_simul();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
